// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and helpers for the parametrised sequence detector
package seq_pkg;

    localparam int ST_IDLE     = 0;
    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int x = value - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// rtl/seq_prefix_match.sv - longest pattern prefix matching the tail of {history, data_in}
module seq_prefix_match
    import seq_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int ST_W    = clog2(PAT_LEN + 1)
) (
    input  logic [PAT_LEN-2:0] history,
    input  logic [ST_W-1:0]    hcnt,
    input  logic               data_in,
    input  logic [PAT_LEN-1:0] pat_q,
    input  logic               restart,
    output logic [ST_W-1:0]    next_state
);

    logic [PAT_LEN-1:0] w_seq;
    logic [ST_W-1:0]    w_hcnt_eff;
    logic               w_hit;

    // Bit 0 of w_seq is the newest bit; a k-bit tail is compared against pat_q[PAT_LEN-1 -: k].
    always_comb begin
        w_seq      = {history, data_in};
        w_hcnt_eff = restart ? '0 : hcnt;
        next_state = ST_W'(ST_IDLE);
        w_hit      = 1'b0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            w_hit = (k <= int'(w_hcnt_eff) + 1);
            for (int j = 0; j < k; j++) begin
                if (w_seq[j] != pat_q[PAT_LEN-k+j]) begin
                    w_hit = 1'b0;
                end
            end
            if (w_hit) begin
                next_state = ST_W'(k);
            end
        end
    end

endmodule

// File: rtl/seq_detect_moore_param.sv
// rtl/seq_detect_moore_param.sv - programmable-pattern Moore detector with saturating match counter
module seq_detect_moore_param
    import seq_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int ST_W    = clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic               data_in,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               data_out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [ST_W-1:0]    state,
    output logic [ST_W-1:0]    next_state
);

    localparam logic [ST_W-1:0] ST_FULL  = ST_W'(PAT_LEN);
    localparam logic [ST_W-1:0] HCNT_MAX = ST_W'(PAT_LEN - 1);

    logic [ST_W-1:0]    r_state;
    logic [PAT_LEN-2:0] r_hist;
    logic [ST_W-1:0]    r_hcnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [PAT_LEN-1:0] r_pat;
    logic               r_ovl;

    logic               w_restart;
    logic [ST_W-1:0]    w_ns_calc;
    logic [ST_W-1:0]    w_next;
    logic [PAT_LEN-2:0] w_hist_next;
    logic [ST_W-1:0]    w_hcnt_next;

    // In non-overlap mode a completed match discards all history before the next bit.
    assign w_restart = (r_state == ST_FULL) && !r_ovl;

    seq_prefix_match #(
        .PAT_LEN (PAT_LEN),
        .ST_W    (ST_W)
    ) u_match (
        .history    (r_hist),
        .hcnt       (r_hcnt),
        .data_in    (data_in),
        .pat_q      (r_pat),
        .restart    (w_restart),
        .next_state (w_ns_calc)
    );

    always_comb begin
        w_next      = in_valid ? w_ns_calc : r_state;
        w_hist_next = w_restart ? (PAT_LEN-1)'(data_in)
                                : ((r_hist << 1) | (PAT_LEN-1)'(data_in));
        if (w_restart) begin
            w_hcnt_next = ST_W'(1);
        end else if (r_hcnt == HCNT_MAX) begin
            w_hcnt_next = r_hcnt;
        end else begin
            w_hcnt_next = r_hcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_state <= ST_W'(ST_IDLE);
            r_hist  <= '0;
            r_hcnt  <= '0;
            r_cnt   <= '0;
            r_pat   <= pattern;
            r_ovl   <= overlap;
        end else if (in_valid) begin
            r_state <= w_ns_calc;
            r_hist  <= w_hist_next;
            r_hcnt  <= w_hcnt_next;
            if ((w_ns_calc == ST_FULL) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign data_out   = (r_state == ST_FULL);
    assign match_cnt  = r_cnt;
    assign state      = r_state;
    assign next_state = w_next;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb/tb_seq_detect_moore_param.sv - scoreboard bench for seq_detect_moore_param
module tb_seq_detect_moore_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       data_in = 1'b0;
    logic [3:0] pattern = 4'b1101;
    logic       overlap = 1'b1;

    logic       data_out;
    logic [7:0] match_cnt;
    logic [2:0] state;
    logic [2:0] next_state;
    logic       c2_data_out;
    logic [1:0] c2_cnt;
    logic [2:0] c2_state;
    logic [2:0] c2_next_state;

    int n_run  = 0;
    int n_fail = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    seq_detect_moore_param #(.PAT_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .pattern(pattern), .overlap(overlap), .data_out(data_out), .match_cnt(match_cnt),
        .state(state), .next_state(next_state)
    );

    seq_detect_moore_param #(.PAT_LEN(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .pattern(pattern), .overlap(overlap), .data_out(c2_data_out), .match_cnt(c2_cnt),
        .state(c2_state), .next_state(c2_next_state)
    );

    task automatic apply(input logic v, input logic b);
        @(negedge clk);
        in_valid = v;
        data_in  = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [3:0] pat, input logic ovl);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        data_in  = 1'b1;
        pattern  = pat;
        overlap  = ovl;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_run++;
        if (state !== 3'd0 || data_out !== 1'b0 || match_cnt !== 8'd0 || next_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: state=%0d dout=%0d cnt=%0d ns=%0d want 0/0/0/0", state, data_out, match_cnt, next_state);
        end
        rst = 1'b1;
    endtask

    task automatic test_overlap();
        int bits[7] = '{1, 1, 0, 1, 1, 0, 1};
        int sts[7]  = '{1, 2, 3, 4, 2, 3, 4};
        int e;
        do_clear(4'b1101, 1'b1);
        n_run++;
        if (state !== 3'd0 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL ovl_clear: state=%0d cnt=%0d want 0/0", state, match_cnt);
        end
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(sts[i]);
            apply(1'b1, 1'(bits[i]));
            n_run++;
            if (next_state !== 3'(exp_q[0])) begin
                n_fail++;
                $display("FAIL ovl_ns[%0d]: got %0d want %0d", i, next_state, exp_q[0]);
            end
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (state !== 3'(e) || data_out !== (e == 4)) begin
                n_fail++;
                $display("FAIL ovl_state[%0d]: state=%0d dout=%0d want %0d/%0d", i, state, data_out, e, (e == 4));
            end
        end
        n_run++;
        if (match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ovl_cnt: got %0d want 2", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        int bits[7] = '{1, 1, 0, 1, 1, 0, 1};
        int sts[7]  = '{1, 2, 3, 4, 1, 0, 1};
        int e;
        int pulses = 0;
        do_clear(4'b1101, 1'b0);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(sts[i]);
            apply(1'b1, 1'(bits[i]));
            tick();
            e = exp_q.pop_front();
            if (data_out === 1'b1) pulses++;
            n_run++;
            if (state !== 3'(e) || data_out !== (e == 4)) begin
                n_fail++;
                $display("FAIL novl_state[%0d]: state=%0d dout=%0d want %0d/%0d", i, state, data_out, e, (e == 4));
            end
        end
        n_run++;
        if (match_cnt !== 8'd1 || pulses != 1) begin
            n_fail++;
            $display("FAIL novl_cnt: cnt=%0d pulses=%0d want 1/1", match_cnt, pulses);
        end
    endtask

    task automatic test_all_ones();
        int sts_o[6] = '{1, 2, 3, 4, 4, 4};
        int sts_n[8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        int e;
        do_clear(4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(sts_o[i]);
            apply(1'b1, 1'b1);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (state !== 3'(e) || data_out !== (e == 4)) begin
                n_fail++;
                $display("FAIL ones_ovl[%0d]: state=%0d dout=%0d want %0d/%0d", i, state, data_out, e, (e == 4));
            end
        end
        n_run++;
        if (match_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL ones_ovl_cnt: got %0d want 3", match_cnt);
        end
        do_clear(4'b1111, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(sts_n[i]);
            apply(1'b1, 1'b1);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (state !== 3'(e)) begin
                n_fail++;
                $display("FAIL ones_novl[%0d]: got %0d want %0d", i, state, e);
            end
        end
        n_run++;
        if (match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ones_novl_cnt: got %0d want 2", match_cnt);
        end
    endtask

    task automatic test_gaps();
        int bits[5] = '{1, 1, 1, 0, 1};
        int sts[5]  = '{1, 2, 2, 3, 4};
        int e;
        do_clear(4'b1101, 1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(sts[i]);
            apply(1'b1, 1'(bits[i]));
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (state !== 3'(e)) begin
                n_fail++;
                $display("FAIL gap_state[%0d]: got %0d want %0d", i, state, e);
            end
            for (int g = 0; g <= i % 3; g++) begin
                apply(1'b0, 1'(~bits[i]));
                n_run++;
                if (next_state !== 3'(e)) begin
                    n_fail++;
                    $display("FAIL gap_ns[%0d.%0d]: got %0d want %0d", i, g, next_state, e);
                end
                tick();
                n_run++;
                if (state !== 3'(e) || data_out !== (e == 4)) begin
                    n_fail++;
                    $display("FAIL gap_hold[%0d.%0d]: state=%0d dout=%0d want %0d", i, g, state, data_out, e);
                end
            end
        end
        n_run++;
        if (match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bits[4] = '{1, 1, 0, 1};
        int sts[4]  = '{1, 2, 3, 4};
        int e;
        do_clear(4'b1101, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'(bits[i]));
            tick();
        end
        n_run++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_pre: got %0d want 3", state);
        end
        apply(1'b1, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        n_run++;
        if (state !== 3'd0 || data_out !== 1'b0 || match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_rst: state=%0d dout=%0d cnt=%0d want 0/0/0", state, data_out, match_cnt);
        end
        pattern = 4'b0000;
        overlap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(sts[i]);
            apply(1'b1, 1'(bits[i]));
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (state !== 3'(e)) begin
                n_fail++;
                $display("FAIL mid_pin_ignored[%0d]: got %0d want %0d", i, state, e);
            end
        end
        do_clear(4'b0000, 1'b1);
        apply(1'b1, 1'b0);
        tick();
        n_run++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_newpat: got %0d want 1", state);
        end
    endtask

    task automatic test_saturation();
        int exp8;
        int exp2;
        do_clear(4'b1111, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            apply(1'b1, 1'b1);
            tick();
            exp8 = (i >= 4) ? i - 3 : 0;
            exp2 = (exp8 > 3) ? 3 : exp8;
            n_run++;
            if (c2_cnt !== 2'(exp2) || match_cnt !== 8'(exp8)) begin
                n_fail++;
                $display("FAIL sat[%0d]: cnt2=%0d cnt8=%0d want %0d/%0d", i, c2_cnt, match_cnt, exp2, exp8);
            end
        end
        n_run++;
        if (c2_state !== 3'd4 || c2_data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_state: state=%0d dout=%0d want 4/1", c2_state, c2_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_all_ones();
        test_gaps();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_moore_param.md
Name: seq_detect_moore_param

Overview:
Parametrised Moore sequence detector, successor to the fixed-pattern Moore detector. Serial bits are qualified by in_valid and matched against a runtime-programmable pattern of PAT_LEN bits. Overlapping and non-overlapping detection are both supported, and a saturating match counter is provided. State and next_state are exported for debug and bench visibility.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the match counter.
ST_W, clog2(PAT_LEN+1), state width (derived; not to be overridden).

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
clear  input  1  synchronous soft clear, active-high.
in_valid  input  1  data_in is consumed this cycle.
data_in  input  1  serial bit.
pattern  input  PAT_LEN  target sequence; pattern[PAT_LEN-1] is the first bit expected.
overlap  input  1  1 = overlapping detection, 0 = restart after each match.
data_out  output  1  Moore match flag.
match_cnt  output  CNT_W  number of matches since reset/clear; saturating.
state  output  ST_W  current state.
next_state  output  ST_W  combinational next state.

Behaviour:
- Reset: rst is synchronous and active-low. While rst=0 at a clock edge: state=0, history cleared, hcnt=0, match_cnt=0, data_out=0. pattern and overlap are captured into pat_q/ovl_q.
- clear=1 (rst=1): same effect as reset at that edge. The in_valid bit in that cycle is discarded. Priority is rst > clear > in_valid.
- pat_q/ovl_q are loaded only on reset or clear. Changes on the pattern/overlap pins between those events are ignored.
- State meaning: state k (0..PAT_LEN) = length of the longest prefix of pat_q equal to the tail of the accepted bit stream. Only bits since the last reset/clear count, or since the last match when ovl_q=0.
- History: shift register of the last PAT_LEN-1 accepted bits. hcnt = number of valid history bits, saturating at PAT_LEN-1.
- next_state when in_valid=1 is the largest k in 1..min(hcnt+1, PAT_LEN) such that the last k bits of {history, data_in} equal pat_q[PAT_LEN-1 -: k]. If no such k exists, next_state is 0.
- Non-overlap exit: if state==PAT_LEN and ovl_q=0, hcnt is treated as 0 for this computation. next_state is then 1 if data_in==pat_q[PAT_LEN-1], else 0, and the history restarts from that bit.
- in_valid=0: next_state = state, and history, hcnt and match_cnt hold.
- data_out = (state==PAT_LEN), decoded from the state register only. It rises the cycle after the final matching bit is accepted and holds until the next accepted bit.
- match_cnt increments by 1 on every accepted bit with next_state==PAT_LEN. This includes PAT_LEN->PAT_LEN self-loops in overlap mode for periodic patterns. It saturates at 2^CNT_W-1 and never wraps.
- Latency: bit accepted at edge N -> state/data_out valid after edge N; match_cnt updates at the same edge.
- Reset or clear mid-sequence aborts the partial match; no stale history survives.

Decomposition:
- Shared package seq_pkg: clog2 constant function, and localparams ST_IDLE=0 and the legal PAT_LEN bounds.
- Sub-module seq_prefix_match (purely combinational): inputs history, hcnt, data_in, pat_q, restart; output next_state.
- The top module holds the registers, the counter and the reset/clear logic.

Test Plan:
- Defaults, pattern=4'b1101, overlap=1, bits 1,1,0,1,1,0,1 all valid -> state 1,2,3,4,2,3,4; data_out high after bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 (loaded via clear) -> states 1,2,3,4,1,0,1; single data_out pulse; match_cnt=1.
- pattern=4'b1111, overlap=1, six 1s -> data_out high continuously from after bit 4; match_cnt=3. With overlap=0, eight 1s -> match_cnt=2, states ...4,1,2,3,4.
- Fallback and gaps: pattern=4'b1101, bits 1,1,1,0,1 with in_valid=0 cycles between bits -> states 1,2,2,3,4; state holds during gaps; match_cnt=1.
- rst=0 for one edge while state=3 -> next edge state=0, data_out=0, match_cnt=0. A pattern change applied while rst=1 is ignored until the next clear.
- CNT_W=2, pattern=4'b1111, overlap=1, ten 1s -> match_cnt reaches 3 and holds at 3.
